// File: rtl/cpu_types_pkg.sv
// Types shared by the CPU memory interface. The RAM end and the memory
// controller both use them.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/ram_timer.sv
// Latency counter for ram_responder. It counts the cycles of one request and
// saturates at LAT, so it never wraps.
module ram_timer #(
   parameter int unsigned LAT = 2
) (
   input  logic CLK,
   input  logic nRST,
   input  logic clear,
   input  logic enable,
   output logic done,
   output logic hit
);

   localparam logic [3:0] LAT_C = 4'(LAT);

   logic [3:0] count_q;
   logic [3:0] count_d;

   // A restart that is also enabled counts the request's first cycle, so the
   // access lands on cycle LAT+1 whatever the previous count was.
   always_comb begin
      // NOTE: the default assignment comes first so that no path leaves count_d unassigned, which would infer a latch.
      count_d = count_q;
      if (clear) begin
         count_d = enable ? 4'd1 : 4'd0;
      end else if (enable && (count_q != LAT_C)) begin
         count_d = count_q + 4'd1;
      end
   end

   // NOTE: non-blocking assignments keep every flop sampling the pre-edge values, so the clocked blocks do not race each other.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == LAT_C);
   assign hit  = (count_d == LAT_C);

endmodule

// File: rtl/ram_responder.sv
// RAM end of the CPU memory-controller interface. A request is held for LAT
// cycles and then granted one ACCESS cycle. Bad requests report ERROR.
module ram_responder
   import cpu_types_pkg::*;
#(
   parameter int unsigned LAT   = 2,
   parameter int unsigned DEPTH = 1024
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      ramREN,
   input  logic      ramWEN,
   input  word_t     ramaddr,
   input  word_t     ramstore,
   output word_t     ramload,
   output ramstate_t ramstate
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} fsm_t;
   typedef logic [33:0] key_t;

   fsm_t          state_q, state_d;
   key_t          key, key_q;
   logic          req, bad, valid, changed;
   logic          clear, enable, done, hit, access;
   logic [AW-1:0] idx;
   word_t         mem [DEPTH];

   assign key     = {ramREN, ramWEN, ramaddr};
   assign req     = ramREN | ramWEN;
   assign bad     = (ramREN & ramWEN)
                  | (req & ((ramaddr[1:0] != 2'b00) | ((ramaddr >> (AW + 2)) != '0)));
   assign valid   = req & ~bad;
   assign changed = (key != key_q);
   assign idx     = ramaddr[AW+1:2];

   // The count restarts on any new, changed or dropped key and after every access.
   assign clear  = (state_q != WAIT) | ~valid | changed;
   assign enable = valid & (state_q != DONE);

   ram_timer #(.LAT(LAT)) u_timer (
      .CLK   (CLK),
      .nRST  (nRST),
      .clear (clear),
      .enable(enable),
      .done  (done),
      .hit   (hit)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key;
      end
   end

   always_comb begin
      state_d  = state_q;
      access   = 1'b0;
      ramstate = FREE;
      ramload  = '0;
      unique case (state_q)
         IDLE, WAIT: state_d = valid ? (hit ? DONE : WAIT) : IDLE;
         DONE: begin
            // A key still held after the access is a fresh request.
            state_d = valid ? WAIT : IDLE;
            access  = done & ~bad;
         end
         default: state_d = IDLE;
      endcase

      if (bad) begin
         ramstate = ERROR;
      end else if (state_q == DONE) begin
         ramstate = ACCESS;
      end else if (req) begin
         ramstate = BUSY;
      end

      if (access && ramREN) begin
         ramload = mem[idx];
      end
   end

   // NOTE: the memory array takes the asynchronous reset on purpose, because every word must read back zero straight after reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (access && ramWEN) begin
         mem[idx] <= ramstore;
      end
   end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder. It drives a LAT=2/DEPTH=1024 instance and a
// LAT=1/DEPTH=64 instance from the same inputs.
module tb_ram_responder;
   import cpu_types_pkg::*;

   logic      CLK  = 1'b0;
   logic      nRST = 1'b0;
   logic      ren  = 1'b0;
   logic      wen  = 1'b0;
   word_t     addr = '0;
   word_t     data = '0;
   word_t     load2, load1;
   ramstate_t st2, st1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   ram_responder #(.LAT(2), .DEPTH(1024)) dut2 (
      .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
      .ramstore(data), .ramload(load2), .ramstate(st2)
   );

   ram_responder #(.LAT(1), .DEPTH(64)) dut1 (
      .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
      .ramstore(data), .ramload(load1), .ramstate(st1)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: each unit counts how many consecutive cycles a valid key
   // has been held. The cycle after the LAT-th one is the access.
   word_t       mmem [2][1024];
   int          run  [2];
   bit          pend [2];
   logic [33:0] lkey [2];

   function automatic int lat_of(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   function automatic int depth_of(input int u);
      return (u == 0) ? 1024 : 64;
   endfunction

   function automatic bit is_bad(input int u);
      logic rq;
      rq = ren | wen;
      return (ren && wen) || (rq && ((addr % 4) != 0 || addr >= 32'(depth_of(u) * 4)));
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         run[u]  = 0;
         pend[u] = 1'b0;
         lkey[u] = '0;
         for (int i = 0; i < 1024; i++) mmem[u][i] = '0;
      end
   endtask

   task automatic model_expect(input int u, output ramstate_t st, output word_t ld);
      bit bad;
      bad = is_bad(u);
      ld  = '0;
      if (bad)             st = ERROR;
      else if (pend[u])    st = ACCESS;
      else if (ren || wen) st = BUSY;
      else                 st = FREE;
      if (pend[u] && !bad && ren) ld = mmem[u][addr >> 2];
   endtask

   task automatic model_edge();
      for (int u = 0; u < 2; u++) begin
         bit          bad;
         bit          valid;
         logic [33:0] key;
         bad   = is_bad(u);
         valid = (ren || wen) && !bad;
         key   = {ren, wen, addr};
         if (pend[u]) begin
            if (!bad && wen) mmem[u][addr >> 2] = data;
            pend[u] = 1'b0;
            run[u]  = 0;
         end else if (valid) begin
            run[u] = (run[u] > 0 && key == lkey[u]) ? run[u] + 1 : 1;
            if (run[u] == lat_of(u)) pend[u] = 1'b1;
         end else begin
            run[u] = 0;
         end
         lkey[u] = key;
      end
   endtask

   task automatic compare_model(input string tag);
      ramstate_t es;
      word_t     el;
      model_expect(0, es, el);
      check({tag, " lat2 state"}, st2, es);
      check({tag, " lat2 load"}, load2, el);
      model_expect(1, es, el);
      check({tag, " lat1 state"}, st1, es);
      check({tag, " lat1 load"}, load1, el);
   endtask

   task automatic drive(input logic r, input logic w, input word_t a, input word_t d);
      ren  = r;
      wen  = w;
      addr = a;
      data = d;
      @(negedge CLK);
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      model_reset();
      #1;
      compare_model("reset");
      @(posedge CLK);
      #2;
      nRST = 1'b1;
   endtask

   typedef struct {
      logic      ren;
      logic      wen;
      word_t     addr;
      word_t     data;
      ramstate_t st;
      word_t     ld;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, input logic w, input word_t a, input word_t d,
                              input ramstate_t s, input word_t l);
      vec_t x;
      x.ren = r; x.wen = w; x.addr = a; x.data = d; x.st = s; x.ld = l;
      return x;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic  r, w;
      word_t a;
      int    hold;

      model_reset();
      #1;
      check("reset lat2 state", st2, FREE);
      check("reset lat2 load", load2, 32'h0);
      check("reset lat1 state", st1, FREE);
      check("reset lat1 load", load1, 32'h0);
      @(posedge CLK);
      #2;
      nRST = 1'b1;

      // Expected values are for the LAT=2 instance.
      tbl.push_back(v(1, 0, 32'h10, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h10, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h10, 0, ACCESS, 0));
      tbl.push_back(v(1, 0, 32'h10, 0, BUSY, 0));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      tbl.push_back(v(0, 1, 32'h40, 32'hDEADBEEF, BUSY, 0));
      tbl.push_back(v(0, 1, 32'h40, 32'hDEADBEEF, BUSY, 0));
      tbl.push_back(v(0, 1, 32'h40, 32'hDEADBEEF, ACCESS, 0));
      tbl.push_back(v(1, 0, 32'h40, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h40, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h40, 0, ACCESS, 32'hDEADBEEF));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      for (int k = 0; k < 2; k++) begin
         word_t wa, wd;
         wa = (k == 0) ? 32'h8 : 32'hC;
         wd = (k == 0) ? 32'h22222222 : 32'h33333333;
         tbl.push_back(v(0, 1, wa, wd, BUSY, 0));
         tbl.push_back(v(0, 1, wa, wd, BUSY, 0));
         tbl.push_back(v(0, 1, wa, wd, ACCESS, 0));
         tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      end
      tbl.push_back(v(1, 0, 32'h8, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'hC, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'hC, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'hC, 0, ACCESS, 32'h33333333));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      tbl.push_back(v(1, 0, 32'h8, 0, BUSY, 0));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      tbl.push_back(v(1, 0, 32'h8, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h8, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h8, 0, ACCESS, 32'h22222222));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      tbl.push_back(v(0, 1, 32'h80, 32'h1, BUSY, 0));
      tbl.push_back(v(0, 1, 32'h80, 32'h2, BUSY, 0));
      tbl.push_back(v(0, 1, 32'h80, 32'h3, ACCESS, 0));
      tbl.push_back(v(1, 0, 32'h80, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h80, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h80, 0, ACCESS, 32'h3));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      tbl.push_back(v(1, 1, 32'h40, 0, ERROR, 0));
      tbl.push_back(v(1, 1, 32'h40, 0, ERROR, 0));
      tbl.push_back(v(1, 1, 32'h40, 0, ERROR, 0));
      tbl.push_back(v(1, 0, 32'h42, 0, ERROR, 0));
      tbl.push_back(v(0, 1, 32'h42, 32'hBAD, ERROR, 0));
      tbl.push_back(v(0, 1, 32'h42, 32'hBAD, ERROR, 0));
      tbl.push_back(v(0, 1, 32'h42, 32'hBAD, ERROR, 0));
      tbl.push_back(v(0, 1, 32'h1000, 32'hFEED, ERROR, 0));
      tbl.push_back(v(0, 1, 32'h1000, 32'hFEED, ERROR, 0));
      tbl.push_back(v(0, 1, 32'h1000, 32'hFEED, ERROR, 0));
      tbl.push_back(v(1, 0, 32'hFFFFFFFC, 0, ERROR, 0));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      tbl.push_back(v(1, 0, 32'h40, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h40, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h40, 0, ACCESS, 32'hDEADBEEF));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      tbl.push_back(v(1, 0, 32'h0, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h0, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h0, 0, ACCESS, 0));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      tbl.push_back(v(0, 1, 32'hFFC, 32'h5A5A, BUSY, 0));
      tbl.push_back(v(0, 1, 32'hFFC, 32'h5A5A, BUSY, 0));
      tbl.push_back(v(0, 1, 32'hFFC, 32'h5A5A, ACCESS, 0));
      tbl.push_back(v(1, 0, 32'hFFC, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'hFFC, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'hFFC, 0, ACCESS, 32'h5A5A));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));
      tbl.push_back(v(1, 0, 32'h10, 0, BUSY, 0));
      tbl.push_back(v(1, 1, 32'h10, 0, ERROR, 0));
      tbl.push_back(v(1, 0, 32'h10, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h10, 0, BUSY, 0));
      tbl.push_back(v(1, 0, 32'h10, 0, ACCESS, 0));
      tbl.push_back(v(0, 0, 0, 0, FREE, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].data);
         check($sformatf("tbl[%0d] state", i), st2, tbl[i].st);
         check($sformatf("tbl[%0d] load", i), load2, tbl[i].ld);
         tick();
      end

      // Reset during the ACCESS cycle of a write must drop the write.
      drive(0, 1, 32'h20, 32'h1234);
      check("rstwr busy1", st2, BUSY);
      tick();
      drive(0, 1, 32'h20, 32'h1234);
      check("rstwr busy2", st2, BUSY);
      tick();
      drive(0, 1, 32'h20, 32'h1234);
      check("rstwr access", st2, ACCESS);
      #1;
      nRST = 1'b0;
      model_reset();
      ren = 1'b0;
      wen = 1'b0;
      #1;
      check("rstwr in-reset state", st2, FREE);
      check("rstwr in-reset load", load2, 32'h0);
      @(posedge CLK);
      #2;
      nRST = 1'b1;
      for (int k = 0; k < 2; k++) begin
         word_t ra;
         ra = (k == 0) ? 32'h20 : 32'h40;
         drive(1, 0, ra, 0);
         check($sformatf("postrst[%0d] busy1", k), st2, BUSY);
         tick();
         drive(1, 0, ra, 0);
         check($sformatf("postrst[%0d] busy2", k), st2, BUSY);
         tick();
         drive(1, 0, ra, 0);
         check($sformatf("postrst[%0d] state", k), st2, ACCESS);
         check($sformatf("postrst[%0d] load", k), load2, 32'h0);
         tick();
      end
      drive(0, 0, 0, 0);
      tick();

      // Back-to-back accesses on the LAT=1 instance.
      drive(0, 1, 32'h0, 32'hA5A50001);
      check("lat1 wr busy", st1, BUSY);
      tick();
      drive(0, 1, 32'h0, 32'hA5A50001);
      check("lat1 wr access", st1, ACCESS);
      tick();
      drive(0, 0, 0, 0);
      check("lat1 idle", st1, FREE);
      tick();
      for (int k = 0; k < 6; k++) begin
         drive(1, 0, 32'h0, 0);
         check($sformatf("lat1 b2b[%0d] state", k), st1, (k % 2 == 1) ? ACCESS : BUSY);
         check($sformatf("lat1 b2b[%0d] load", k), load1, (k % 2 == 1) ? 32'hA5A50001 : 32'h0);
         tick();
      end
      drive(0, 0, 0, 0);
      tick();

      // Random traffic with held keys and occasional async resets.
      hold = 0;
      r = 1'b0;
      w = 1'b0;
      a = '0;
      for (int i = 0; i < 2500; i++) begin
         if (hold == 0) begin
            int k, m;
            k = $urandom_range(0, 9);
            r = (k < 4) || (k == 9);
            w = (k >= 4 && k < 8) || (k == 9);
            m = $urandom_range(0, 9);
            if (m < 7)       a = 32'($urandom_range(0, 63)) * 4;
            else if (m == 7) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            else if (m == 8) a = 32'($urandom_range(64, 1023)) * 4;
            else             a = 32'h1000 + 32'($urandom_range(0, 4095)) * 4;
            hold = $urandom_range(1, 6);
         end
         hold--;
         if ($urandom_range(0, 199) == 0) do_reset();
         drive(r, w, a, $urandom);
         compare_model("rnd");
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
